// File: rtl/mult_operand_sequencer.sv
// Operand FIFO and start/ready sequencer feeding add_shift_multiplier.
// Optional GUARD+WAIT watchdog is compiled in when SEQ_TIMEOUT_EN is defined.
//
// state   | meaning
// S_IDLE  | wait for a queued pair and an empty output register
// S_START | mul_start high; operands already registered on mul_a/mul_b
// S_GUARD | MIN_WAIT cycles during which mul_ready is ignored
// S_WAIT  | wait for mul_ready, then capture mul_r into out_r
module mult_operand_sequencer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int MIN_WAIT = 1,
  parameter int TIMEOUT  = 31
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     mul_start,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [2*WIDTH-1:0]       mul_r,
  input  logic                     mul_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_r,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = (MIN_WAIT > 1) ? $clog2(MIN_WAIT) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mult_operand_sequencer: DEPTH must be a power of two >= 2");
  end
  if (MIN_WAIT < 1 || TIMEOUT < 1) begin : g_bad_wait
    $error("mult_operand_sequencer: MIN_WAIT and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_GUARD = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              push;
  logic              pop;
  logic              capture;
  logic              tmo_fire;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [GW-1:0]     guard_cnt;
  logic [WIDTH-1:0]  mem_a [DEPTH];
  logic [WIDTH-1:0]  mem_b [DEPTH];

  assign push = in_valid && in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Pop only against the registered out_valid, so a same-cycle
  // output handshake never lets a new pair issue.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    capture  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_count != '0 && !out_valid) begin
          pop      = 1'b1;
          state_nx = S_START;
        end
      end
      S_START: state_nx = S_GUARD;
      S_GUARD: begin
        if (tmo_fire)               state_nx = S_IDLE;
        else if (guard_cnt == '0)   state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (mul_ready) begin
          capture  = 1'b1;
          state_nx = S_IDLE;
        end else if (tmo_fire) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mul_start = (state == S_START);
    in_ready  = (fifo_count < CW'(DEPTH));
  end

  // ---------------------------------------------------------------- guard timer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      guard_cnt <= '0;
    end else if (state == S_START) begin
      guard_cnt <= GW'(MIN_WAIT - 1);
    end else if (state == S_GUARD && guard_cnt != '0) begin
      guard_cnt <= guard_cnt - GW'(1);
    end
  end

  // ---------------------------------------------------------------- watchdog
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_cnt;

  // Terminal count reached on the TIMEOUT-th GUARD/WAIT cycle.
  assign tmo_fire = (state == S_GUARD || (state == S_WAIT && !mul_ready))
                    && tmo_cnt == '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= TW'(TIMEOUT - 1);
    end else if ((state == S_GUARD || state == S_WAIT) && tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        timeout_err <= 1'b0;
    else if (tmo_fire) timeout_err <= 1'b1;
  end
`else
  assign tmo_fire    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // ---------------------------------------------------------------- operand FIFO
  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Operands change only on a pop, so they are stable for the whole multiply.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else if (pop) begin
      mul_a <= mem_a[rd_ptr];
      mul_b <= mem_b[rd_ptr];
    end
  end

  // ---------------------------------------------------------------- product register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_r     <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_r     <= mul_r;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Self-checking bench for mult_operand_sequencer with a behavioural
// shift-add multiplier model (WIDTH-cycle latency, ready high when idle).
module tb_mult_operand_sequencer;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   in_a = '0;
  logic [W-1:0]   in_b = '0;
  logic           in_ready, mul_start, out_valid, timeout_err, mul_ready;
  logic [W-1:0]   mul_a, mul_b;
  logic [2*W-1:0] mul_r, out_r;
  logic [2:0]     fifo_count;

  int             checks = 0;
  int             errors = 0;
  logic [15:0]    exp_q[$];

  logic           stuck = 1'b0;
  int             mdl_cnt;
  logic [W-1:0]   ma, mb;
  int             start_cnt = 0;
  int             overlap_cnt = 0;

  mult_operand_sequencer #(.WIDTH(W), .DEPTH(4), .MIN_WAIT(1), .TIMEOUT(31)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_r(mul_r), .mul_ready(mul_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Multiplier model; 'stuck' freezes it busy to exercise the watchdog.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_ready <= 1'b1;
      mul_r     <= '0;
      mdl_cnt   <= 0;
    end else if (mul_start) begin
      mul_ready <= 1'b0;
      ma        <= mul_a;
      mb        <= mul_b;
      mdl_cnt   <= W;
    end else if (!mul_ready && !stuck) begin
      if (mdl_cnt <= 1) begin
        mul_ready <= 1'b1;
        mul_r     <= 16'(ma) * 16'(mb);
      end else begin
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end

  always @(negedge clock) begin
    if (mul_start) begin
      start_cnt = start_cnt + 1;
      if (!mul_ready && !stuck) overlap_cnt = overlap_cnt + 1;
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic exp_acc);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    if (exp_acc) exp_q.push_back(16'(a) * 16'(b));
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic got, output logic [15:0] r);
    got = 1'b0;
    r   = '0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (out_valid && out_ready) begin
        got = 1'b1;
        r   = out_r;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (mul_start !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1 ||
        timeout_err !== 1'b0 || mul_a !== 8'h00 || mul_b !== 8'h00 || out_r !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: start=%b ov=%b cnt=%0d rdy=%b tmo=%b a=%h b=%h r=%h (want 0 0 0 1 0 00 00 0000)",
               mul_start, out_valid, fifo_count, in_ready, timeout_err, mul_a, mul_b, out_r);
    end
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (mul_start !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_reset: start=%b cnt=%0d (want 0 0)", mul_start, fifo_count);
    end
  endtask

  task automatic test_single_pair();
    logic got;
    logic [15:0] r, e;
    int s0;
    out_ready = 1'b1;
    s0 = start_cnt;
    push(8'h03, 8'h04, 1'b1);
    checks++;
    if (fifo_count !== 3'd1 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL single_after_push: cnt=%0d start=%b (want 1 0)", fifo_count, mul_start);
    end
    @(posedge clock); #1;
    checks++;
    if (mul_start !== 1'b1 || mul_a !== 8'h03 || mul_b !== 8'h04 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_start: start=%b a=%h b=%h cnt=%0d (want 1 03 04 0)",
               mul_start, mul_a, mul_b, fifo_count);
    end
    @(posedge clock); #1;
    checks++;
    if (mul_start !== 1'b0) begin
      errors++;
      $display("FAIL single_start_width: start=%b (want 0)", mul_start);
    end
    wait_out(got, r);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (!got || r !== e) begin
      errors++;
      $display("FAIL single_product: got=%b r=%h (want 1 %h)", got, r, e);
    end
    checks++;
    if (out_valid !== 1'b0 || start_cnt - s0 != 1) begin
      errors++;
      $display("FAIL single_one_shot: ov=%b starts=%0d (want 0 1)", out_valid, start_cnt - s0);
    end
  endtask

  task automatic test_back_to_back();
    logic got;
    logic [15:0] r, e;
    int s0, ov0;
    s0  = start_cnt;
    ov0 = overlap_cnt;
    out_ready = 1'b1;
    push(8'h03, 8'h04, 1'b1);
    push(8'h34, 8'h04, 1'b1);
    checks++;
    if (fifo_count !== 3'd1 || mul_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_push_pop: cnt=%0d start=%b (want 1 1)", fifo_count, mul_start);
    end
    for (int i = 0; i < 2; i++) begin
      wait_out(got, r);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (!got || r !== e) begin
        errors++;
        $display("FAIL b2b_product[%0d]: got=%b r=%h (want 1 %h)", i, got, r, e);
      end
    end
    checks++;
    if (start_cnt - s0 != 2 || overlap_cnt != ov0) begin
      errors++;
      $display("FAIL b2b_starts: starts=%0d overlaps=%0d (want 2 0)", start_cnt - s0, overlap_cnt - ov0);
    end
  endtask

  task automatic test_full_fifo();
    logic got, e_acc;
    logic [15:0] r, e;
    int s0, ov0;
    s0  = start_cnt;
    ov0 = overlap_cnt;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      e_acc = (i < 5);
      checks++;
      if (in_ready !== e_acc) begin
        errors++;
        $display("FAIL full_in_ready[%0d]: in_ready=%b (want %b)", i, in_ready, e_acc);
      end
      push(8'(16 + 7 * i), 8'(3 + i), e_acc);
    end
    repeat (15) @(posedge clock);
    #1;
    checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_level: cnt=%0d rdy=%b ov=%b (want 4 0 1)", fifo_count, in_ready, out_valid);
    end
    // Offer a pair while full and release the output in the same cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'hA5;
    in_b      = 8'h5A;
    wait_out(got, r);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (!got || r !== e) begin
      errors++;
      $display("FAIL full_product[0]: got=%b r=%h (want 1 %h)", got, r, e);
    end
    checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: cnt=%0d rdy=%b (want 4 0)", fifo_count, in_ready);
    end
    @(posedge clock); #1;
    checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1 || mul_start !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: cnt=%0d rdy=%b start=%b (want 3 1 1)", fifo_count, in_ready, mul_start);
    end
    exp_q.push_back(16'hA5 * 16'h5A);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_refill: cnt=%0d (want 4)", fifo_count);
    end
    for (int i = 1; i < 6; i++) begin
      wait_out(got, r);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      checks++;
      if (!got || r !== e) begin
        errors++;
        $display("FAIL full_product[%0d]: got=%b r=%h (want 1 %h)", i, got, r, e);
      end
    end
    checks++;
    if (fifo_count !== 3'd0 || start_cnt - s0 != 6 || overlap_cnt != ov0) begin
      errors++;
      $display("FAIL full_drain: cnt=%0d starts=%0d overlaps=%0d (want 0 6 0)",
               fifo_count, start_cnt - s0, overlap_cnt - ov0);
    end
  endtask

  task automatic test_reset_mid_op();
    int s0, seen;
    out_ready = 1'b1;
    push(8'd11, 8'd13, 1'b1);
    push(8'd7, 8'd9, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (mul_a !== 8'd11 || mul_b !== 8'd13) begin
      errors++;
      $display("FAIL operand_stable: a=%0d b=%0d (want 11 13)", mul_a, mul_b);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (mul_start !== 1'b0 || out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_wait: start=%b ov=%b cnt=%0d rdy=%b (want 0 0 0 1)",
               mul_start, out_valid, fifo_count, in_ready);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    s0   = start_cnt;
    seen = 0;
    repeat (30) begin
      @(posedge clock); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || start_cnt != s0) begin
      errors++;
      $display("FAIL reset_flush: products=%0d starts=%0d (want 0 0)", seen, start_cnt - s0);
    end
    // Reset while mul_start is high must drop it without waiting for a clock.
    push(8'd5, 8'd6, 1'b1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    checks++;
    if (mul_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_async: start=%b (want 0)", mul_start);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    int n, ov;
    stuck     = 1'b1;
    out_ready = 1'b1;
    ov        = 0;
    push(8'h21, 8'h02, 1'b1);
    push(8'h42, 8'h03, 1'b1);
`ifdef SEQ_TIMEOUT_EN
    checks++;
    if (mul_start !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_start: start=%b tmo=%b (want 1 0)", mul_start, timeout_err);
    end
    n = 0;
    while (timeout_err !== 1'b1 && n < 60) begin
      @(posedge clock); #1;
      n++;
      if (out_valid) ov++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL tmo_latency: edges after start=%0d (want 32)", n);
    end
    @(posedge clock); #1;
    checks++;
    if (mul_start !== 1'b1 || mul_a !== 8'h42 || ov != 0 || out_valid !== 1'b0 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL tmo_recover: start=%b a=%h products=%0d ov=%b tmo=%b (want 1 42 0 0 1)",
               mul_start, mul_a, ov, out_valid, timeout_err);
    end
    stuck = 1'b0;
    do_reset();
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL tmo_clear: tmo=%b (want 0)", timeout_err);
    end
`else
    n = 0;
    repeat (60) begin
      @(posedge clock); #1;
      n++;
      if (out_valid) ov++;
    end
    checks++;
    if (timeout_err !== 1'b0 || ov != 0 || mul_a !== 8'h21 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL no_watchdog: tmo=%b products=%0d a=%h cnt=%0d after %0d cycles (want 0 0 21 1)",
               timeout_err, ov, mul_a, fifo_count, n);
    end
    stuck = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single_pair();
    test_back_to_back();
    test_full_fifo();
    test_reset_mid_op();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_operand_sequencer.md
# mult_operand_sequencer

Upstream feeder for `add_shift_multiplier`: buffers operand pairs from a producer in a small FIFO and issues them one at a time with a single-cycle `start` pulse. It waits for the multiplier's `ready`, captures the 16-bit product, and holds it in a valid/ready output register. This replaces hand-driven `start` sequencing and guarantees operands are stable for the whole multiply.

## Interface
- `WIDTH`, 8: operand width; product is 2*WIDTH.
- `DEPTH`, 4: operand FIFO depth, power of two, ≥2.
- `MIN_WAIT`, 1: cycles after `start` during which `mul_ready` is ignored.
- `TIMEOUT`, 31: max GUARD+WAIT cycles before abort (with `SEQ_TIMEOUT_EN` only).
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; `count < DEPTH`.
- `in_a`, `in_b`  in  WIDTH  operands.
- `mul_start`  out  1  one-cycle start pulse to multiplier.
- `mul_a`, `mul_b`  out  WIDTH  operands to multiplier, registered.
- `mul_r`  in  2*WIDTH  multiplier product.
- `mul_ready`  in  1  multiplier done/idle level.
- `out_valid`  out  1  product held in `out_r`.
- `out_ready`  in  1  consumer accepts product.
- `out_r`  out  2*WIDTH  captured product.
- `fifo_count`  out  log2(DEPTH)+1  current FIFO occupancy.
- `timeout_err`  out  1  sticky watchdog flag.

## Operation
- Push on `in_valid && in_ready`. `in_ready` derives from registered count only; there is no full-bypass. Pointers wrap mod DEPTH.
- FSM states: IDLE, START, GUARD, WAIT.
- IDLE: if `count != 0 && !out_valid`, pop the head into `mul_a`/`mul_b` and go to START. Otherwise stay in IDLE.
- START: `mul_start=1` for exactly this cycle, then go to GUARD.
- GUARD: hold for MIN_WAIT cycles ignoring `mul_ready`, then go to WAIT.
- WAIT: on `mul_ready==1`, load `out_r<=mul_r`, set `out_valid<=1`, and go to IDLE.
- `out_valid` clears on `out_valid && out_ready`. The pop in IDLE requires `out_valid==0` as registered; a same-cycle handshake does not allow a pop.
- Simultaneous push and pop: count stays unchanged and both occur. A push while full is refused and the data is ignored.
- `mul_a`/`mul_b` stay stable from the pop until the next pop.
- Reset values: `mul_start=0`, `mul_a=mul_b=0`, `out_valid=0`, `out_r=0`, `fifo_count=0`, `in_ready=1`, `timeout_err=0`, FSM=IDLE.
- Reset mid-operation flushes the FIFO, discards any in-flight product, and deasserts `mul_start` immediately.

## Timing
- Push at edge N gives `fifo_count` updated at N+1. IDLE pops at edge N+1, and `mul_start` is high in cycle N+1..N+2. Empty-FIFO latency from push to start is 2 cycles.
- `mul_ready` sampled high at edge M gives `out_valid` high from M. Earliest next `mul_start` is 2 cycles after `out_valid` falls.
- Throughput is one product per multiply plus 3 cycles of overhead, assuming `out_ready` is held high.

## Configuration
- `SEQ_TIMEOUT_EN` defined: a counter runs in GUARD+WAIT. When it reaches TIMEOUT with `mul_ready` never seen in WAIT:
  - `timeout_err` sets (sticky until reset);
  - the product is dropped and `out_valid` stays 0;
  - the FSM returns to IDLE.
- `SEQ_TIMEOUT_EN` undefined: no counter; WAIT blocks indefinitely and `timeout_err` is tied to 0.

## Test plan
- Single pair: push 0x03/0x04 into the bench `add_shift_multiplier` with `out_ready=1`. Expect one `mul_start` pulse 2 cycles after the push, then `out_r=0x000C` with `out_valid` for 1 cycle.
- Back-to-back: push 0x03/0x04 then 0x34/0x04 on consecutive cycles. Expect two start pulses, in order, never overlapping a multiply, and `out_r` showing 0x000C then 0x00D0.
- Full FIFO: hold `out_ready=0` and push 6 pairs. Expect `fifo_count` to reach 4 with `in_ready=0`, and the 6th push refused. Then release `out_ready` and expect 5 products in order.
- Push while full with a same-cycle pop: `count` stays 4 and no entry is lost or duplicated.
- Reset mid-WAIT: drop `reset` low. Expect `mul_start=0`, `out_valid=0`, `fifo_count=0` immediately, and no product after release.
- With `SEQ_TIMEOUT_EN`: use a mock multiplier holding `mul_ready=0`. Expect `timeout_err=1` at 31 GUARD+WAIT cycles, no `out_valid`, and the next pair issued.
